// File: rtl/record_core_if.sv
// Recording bus: control from the top-level controller, sample stream in, SDRAM write requests out.
interface record_core_if;
  logic        rec_start;
  logic [22:0] rec_select;
  logic        rec_pause;
  logic        rec_stop;
  logic        rec_done;
  logic [22:0] rec_length;
  logic        rec_write;
  logic [22:0] rec_addr;
  logic [31:0] rec_writedata;
  logic        rec_sdram_finished;
  logic        rec_audio_valid;
  logic [31:0] rec_audio_data;
  logic        rec_audio_ready;

  modport master (
    input  rec_start, rec_select, rec_pause, rec_stop,
    input  rec_sdram_finished, rec_audio_valid, rec_audio_data,
    output rec_done, rec_length, rec_write, rec_addr, rec_writedata, rec_audio_ready
  );

  modport slave (
    output rec_start, rec_select, rec_pause, rec_stop,
    output rec_sdram_finished, rec_audio_valid, rec_audio_data,
    input  rec_done, rec_length, rec_write, rec_addr, rec_writedata, rec_audio_ready
  );
endinterface

// File: rtl/record_core.sv
// Audio capture: each sample goes to SDRAM at base+1+count, then the count is written at base.
// One write in flight; ready is withheld until it is finished, so a sample costs 2 cycles plus SDRAM latency.
module record_core #(
  parameter logic [22:0] MAX_LEN = 23'd1048575
) (
  input  logic          i_clk,
  input  logic          i_rst,
  record_core_if.master rec
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, WRITE_LENGTH} state_t;

  state_t      state, state_nxt;
  logic [22:0] base, base_nxt;
  logic [22:0] count, count_nxt;
  logic [22:0] count_inc;
  logic [31:0] sample, sample_nxt;
  logic        stop_pending, stop_pending_nxt;
  logic [22:0] length_q, length_nxt;
  logic        done_q, done_nxt;

  logic        audio_ready;
  logic        write;
  logic [22:0] addr;
  logic [31:0] writedata;

  assign count_inc = count + 23'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      base         <= '0;
      count        <= '0;
      sample       <= '0;
      stop_pending <= 1'b0;
      length_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      base         <= base_nxt;
      count        <= count_nxt;
      sample       <= sample_nxt;
      stop_pending <= stop_pending_nxt;
      length_q     <= length_nxt;
      done_q       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    base_nxt         = base;
    count_nxt        = count;
    sample_nxt       = sample;
    stop_pending_nxt = stop_pending;
    length_nxt       = length_q;
    done_nxt         = 1'b0;
    case (state)
      IDLE: begin
        if (rec.rec_start) begin
          base_nxt         = rec.rec_select;
          count_nxt        = '0;
          stop_pending_nxt = 1'b0;
          state_nxt        = WAIT;
        end
      end
      WAIT: begin
        // Stop wins over a sample offered in the same cycle.
        if (rec.rec_stop || count == MAX_LEN) begin
          state_nxt = WRITE_LENGTH;
        end else if (rec.rec_audio_valid && audio_ready) begin
          sample_nxt = rec.rec_audio_data;
          state_nxt  = WRITE;
        end
      end
      WRITE: begin
        // The sample write always completes so the stored length matches the stored data.
        if (rec.rec_stop) stop_pending_nxt = 1'b1;
        if (rec.rec_sdram_finished) begin
          count_nxt = count_inc;
          if (stop_pending || rec.rec_stop || count_inc == MAX_LEN) state_nxt = WRITE_LENGTH;
          else                                                       state_nxt = WAIT;
        end
      end
      WRITE_LENGTH: begin
        if (rec.rec_sdram_finished) begin
          length_nxt = count;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    audio_ready = 1'b0;
    write       = 1'b0;
    addr        = '0;
    writedata   = '0;
    case (state)
      WAIT: audio_ready = !rec.rec_pause && !rec.rec_stop;
      WRITE: begin
        write     = 1'b1;
        addr      = base + count_inc;
        writedata = sample;
      end
      WRITE_LENGTH: begin
        write     = 1'b1;
        addr      = base;
        writedata = {9'b0, count};
      end
      default: ;
    endcase
  end

  assign rec.rec_audio_ready = audio_ready;
  assign rec.rec_write       = write;
  assign rec.rec_addr        = addr;
  assign rec.rec_writedata   = writedata;
  assign rec.rec_done        = done_q;
  assign rec.rec_length      = length_q;

endmodule

// File: tb/tb_record_core.sv
// Bench for record_core: SDRAM responder with random latency, per-cycle scoreboard, directed scenarios, random recordings.
module tb_record_core;
  localparam logic [22:0] MAXL = 23'd4;

  logic clk = 1'b0;
  logic rst;
  record_core_if bus();
  record_core #(.MAX_LEN(MAXL)) dut (.i_clk(clk), .i_rst(rst), .rec(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat_fixed = -1;
  int lat_max = 0;
  int done_cnt = 0;
  logic [31:0] mem [logic [22:0]];
  logic [22:0] wlog [$];
  logic [22:0] elog [$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] rd(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hxxxxxxxx;
  endfunction

  task automatic chk_log(input string nm, input logic [22:0] e [$]);
    chk({nm, "_count"}, 64'(wlog.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < wlog.size(); i++) chk(nm, 64'(wlog[i]), 64'(e[i]));
  endtask

  // SDRAM arbiter stand-in: accepts each request after a random or forced delay.
  initial begin : sdram
    int  wc;
    bit  busy;
    busy = 1'b0;
    wc   = 0;
    bus.rec_sdram_finished = 1'b0;
    forever begin
      @(negedge clk);
      bus.rec_sdram_finished = 1'b0;
      if (rst || !bus.rec_write) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wc   = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max, 0));
        end
        if (wc == 0) begin
          bus.rec_sdram_finished = 1'b1;
          busy = 1'b0;
          mem[bus.rec_addr] = bus.rec_writedata;
          wlog.push_back(bus.rec_addr);
        end else begin
          wc--;
        end
      end
    end
  end

  // Scoreboard: a recording session is a list of accepted samples; the SDRAM image must be
  // the length word at base followed by those samples, with exactly one write outstanding.
  initial begin : monitor
    bit          open, pend_v, pend_len, stop_seen, done_next, exp_ready;
    logic [22:0] mbase, n, last_len, pend_addr;
    logic [31:0] pend_data;
    logic [31:0] acc_q [$];
    open = 0; pend_v = 0; pend_len = 0; stop_seen = 0; done_next = 0;
    mbase = '0; n = '0; last_len = '0; pend_addr = '0; pend_data = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        open = 0; pend_v = 0; done_next = 0; last_len = '0;
      end
      exp_ready = open && !pend_v && !bus.rec_pause && !bus.rec_stop;
      chk("write",  64'(bus.rec_write),       64'(pend_v));
      chk("addr",   64'(bus.rec_addr),        pend_v ? 64'(pend_addr) : 64'd0);
      chk("wdata",  64'(bus.rec_writedata),   pend_v ? 64'(pend_data) : 64'd0);
      chk("ready",  64'(bus.rec_audio_ready), 64'(exp_ready));
      chk("done",   64'(bus.rec_done),        64'(done_next));
      chk("length", 64'(bus.rec_length),      64'(last_len));
      if (bus.rec_done) done_cnt++;
      done_next = 0;
      if (!rst) begin
        if (!open) begin
          if (bus.rec_start) begin
            open = 1; mbase = bus.rec_select; n = '0; stop_seen = 0;
            acc_q.delete();
          end
        end else if (!pend_v) begin
          if (bus.rec_stop || n == MAXL) begin
            pend_v = 1; pend_len = 1; pend_addr = mbase; pend_data = {9'b0, n};
          end else if (bus.rec_audio_valid && exp_ready) begin
            acc_q.push_back(bus.rec_audio_data);
            pend_v = 1; pend_len = 0;
            pend_addr = mbase + 23'd1 + n;
            pend_data = bus.rec_audio_data;
          end
        end else begin
          if (bus.rec_stop) stop_seen = 1;
          if (bus.rec_sdram_finished) begin
            if (pend_len) begin
              pend_v = 0; open = 0; done_next = 1; last_len = n;
              chk("image_len", 64'(rd(mbase)), 64'({9'b0, n}));
              for (int i = 0; i < acc_q.size(); i++)
                chk("image_sample", 64'(rd(mbase + 23'd1 + 23'(i))), 64'(acc_q[i]));
            end else begin
              n = n + 23'd1;
              if (stop_seen || n == MAXL) begin
                pend_len = 1; pend_addr = mbase; pend_data = {9'b0, n};
              end else begin
                pend_v = 0;
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic start_rec(input logic [22:0] b);
    bus.rec_start  = 1'b1;
    bus.rec_select = b;
    @(negedge clk);
    bus.rec_start  = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.rec_stop = 1'b1;
    @(negedge clk);
    bus.rec_stop = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] d, input int tmo, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    bus.rec_audio_valid = 1'b1;
    bus.rec_audio_data  = d;
    while (!ok && t < tmo) begin
      #2;
      ok = bus.rec_audio_ready;
      @(negedge clk);
      t++;
    end
    bus.rec_audio_valid = 1'b0;
  endtask

  task automatic send_ok(input logic [31:0] d);
    bit ok;
    send_sample(d, 100, ok);
    chk("sample_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int c0, input string nm);
    int t;
    t = 0;
    while (done_cnt == c0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(done_cnt), 64'(c0 + 1));
  endtask

  function automatic logic [22:0] rand_base();
    if ($urandom_range(3, 0) == 0) return 23'h7FFFFC + 23'($urandom_range(3, 0));
    return 23'($urandom);
  endfunction

  initial begin : main
    int   c0, t, rc;
    bit   ok, got, b2b;
    rst = 1'b1;
    bus.rec_start = 0; bus.rec_select = '0; bus.rec_pause = 0; bus.rec_stop = 0;
    bus.rec_audio_valid = 0; bus.rec_audio_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_write",  64'(bus.rec_write),       64'd0);
    chk("reset_ready",  64'(bus.rec_audio_ready), 64'd0);
    chk("reset_done",   64'(bus.rec_done),        64'd0);
    chk("reset_length", 64'(bus.rec_length),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic recording of three samples.
    lat_max = 2; wlog.delete(); c0 = done_cnt;
    start_rec(23'h000100);
    send_ok(32'hAAAA0001);
    send_ok(32'hBBBB0002);
    send_ok(32'hCCCC0003);
    pulse_stop();
    wait_done(c0, "basic_done");
    elog = '{23'h101, 23'h102, 23'h103, 23'h100};
    chk_log("basic_log", elog);
    chk("basic_length", 64'(bus.rec_length), 64'd3);
    chk("basic_lenword", 64'(rd(23'h100)), 64'h00000003);
    chk("basic_s2", 64'(rd(23'h102)), 64'hBBBB0002);

    // Pause blocks acceptance; the next sample lands right after the previous one.
    c0 = done_cnt;
    start_rec(23'h000700);
    send_ok(32'h11110001);
    t = 0;
    while (bus.rec_write && t < 50) begin @(negedge clk); t++; end
    wlog.delete(); rc = 0;
    bus.rec_pause = 1'b1; bus.rec_audio_valid = 1'b1; bus.rec_audio_data = 32'hDEAD0002;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.rec_audio_ready) rc++;
      @(negedge clk);
    end
    chk("pause_ready_cycles", 64'(rc), 64'd0);
    chk("pause_writes", 64'(wlog.size()), 64'd0);
    bus.rec_pause = 1'b0;
    send_ok(32'hDEAD0002);
    pulse_stop();
    wait_done(c0, "pause_done");
    elog = '{23'h702, 23'h700};
    chk_log("pause_log", elog);
    chk("pause_sample", 64'(rd(23'h702)), 64'hDEAD0002);
    chk("pause_length", 64'(bus.rec_length), 64'd2);

    // Stop while a slow sample write is in flight.
    lat_fixed = 5; wlog.delete(); c0 = done_cnt;
    start_rec(23'h000200);
    send_ok(32'h12345678);
    pulse_stop();
    wait_done(c0, "stopmid_done");
    lat_fixed = -1;
    elog = '{23'h201, 23'h200};
    chk_log("stopmid_log", elog);
    chk("stopmid_length", 64'(bus.rec_length), 64'd1);

    // Stop together with valid in WAIT: the sample is dropped.
    wlog.delete(); c0 = done_cnt;
    start_rec(23'h000300);
    bus.rec_audio_valid = 1'b1; bus.rec_audio_data = 32'h0BAD0BAD; bus.rec_stop = 1'b1;
    @(negedge clk);
    bus.rec_audio_valid = 1'b0; bus.rec_stop = 1'b0;
    wait_done(c0, "stopvalid_done");
    elog = '{23'h300};
    chk_log("stopvalid_log", elog);
    chk("stopvalid_length", 64'(bus.rec_length), 64'd0);

    // Region full after MAX_LEN samples.
    wlog.delete(); c0 = done_cnt;
    start_rec(23'h000400);
    for (int i = 0; i < 6; i++) begin
      send_sample(32'h40000000 + 32'(i), 20, ok);
      chk("full_accept", 64'(ok), (i < 4) ? 64'd1 : 64'd0);
    end
    wait_done(c0, "full_done");
    elog = '{23'h401, 23'h402, 23'h403, 23'h404, 23'h400};
    chk_log("full_log", elog);
    chk("full_length", 64'(bus.rec_length), 64'd4);

    // Sample addresses wrap at the top of the address space.
    wlog.delete(); c0 = done_cnt;
    start_rec(23'h7FFFFE);
    send_ok(32'h77770001);
    send_ok(32'h77770002);
    pulse_stop();
    wait_done(c0, "wrap_done");
    elog = '{23'h7FFFFF, 23'h000000, 23'h7FFFFE};
    chk_log("wrap_log", elog);
    chk("wrap_lenword", 64'(rd(23'h7FFFFE)), 64'h00000002);
    chk("wrap_sample", 64'(rd(23'h000000)), 64'h77770002);

    // Reset during a sample write, then an empty recording.
    lat_fixed = 10;
    start_rec(23'h000500);
    send_ok(32'h55555555);
    rst = 1'b1;
    #1;
    chk("rstmid_write",  64'(bus.rec_write),       64'd0);
    chk("rstmid_addr",   64'(bus.rec_addr),        64'd0);
    chk("rstmid_wdata",  64'(bus.rec_writedata),   64'd0);
    chk("rstmid_ready",  64'(bus.rec_audio_ready), 64'd0);
    chk("rstmid_length", 64'(bus.rec_length),      64'd0);
    @(negedge clk);
    rst = 1'b0; lat_fixed = -1;
    @(negedge clk);
    wlog.delete(); c0 = done_cnt;
    start_rec(23'h000600);
    pulse_stop();
    wait_done(c0, "empty_done");
    elog = '{23'h600};
    chk_log("empty_log", elog);
    chk("empty_lenword", 64'(rd(23'h600)), 64'h00000000);

    // Random recordings, sometimes restarted in the same cycle as done.
    b2b = 1'b0;
    for (int r = 0; r < 40; r++) begin
      lat_max = int'($urandom_range(3, 0));
      c0 = done_cnt;
      if (!b2b) start_rec(rand_base());
      b2b = 1'b0;
      got = 1'b0;
      t = 0;
      while (!got && t < 400) begin
        bus.rec_audio_valid = ($urandom_range(9, 0) < 7);
        bus.rec_audio_data  = $urandom;
        bus.rec_pause       = ($urandom_range(9, 0) < 2);
        bus.rec_stop        = ($urandom_range(29, 0) == 0);
        #2;
        if (bus.rec_done) begin
          got = 1'b1;
          if (r < 39 && $urandom_range(1, 0) == 1) begin
            bus.rec_start  = 1'b1;
            bus.rec_select = rand_base();
            b2b = 1'b1;
          end
        end
        @(negedge clk);
        bus.rec_start = 1'b0;
        t++;
      end
      bus.rec_audio_valid = 0; bus.rec_pause = 0; bus.rec_stop = 0;
      chk("rand_done", 64'(done_cnt), 64'(c0 + 1));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/record_core.md
# record_core

Audio capture engine that writes the same SDRAM layout `PlayCore` reads back: a length word at the base address, followed by one 32-bit sample per word. It sits between the audio ADC path and the SDRAM arbiter and is controlled by the top-level controller. It accepts samples over a valid/ready handshake and writes each one to SDRAM. On stop, or when the region is full, it writes the sample count to the base address and pulses done.

## Interface
- `MAX_LEN`, default 23'd1048575: maximum samples per recording. Must be 1 to 2^23−2.
- `i_clk`  in  1: clock, single domain.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `rec_start`  in  1: begin recording. Honoured only in IDLE.
- `rec_select`  in  23: base address. Latched on accepted start.
- `rec_pause`  in  1: level. While high, no samples are accepted.
- `rec_stop`  in  1: pulse or level. Ends recording.
- `rec_done`  out  1: one-cycle pulse after the length word is committed.
- `rec_length`  out  23: sample count of the last completed recording.
- `rec_write`  out  1: SDRAM write request, held until finished.
- `rec_addr`  out  23: SDRAM address.
- `rec_writedata`  out  32: SDRAM write data.
- `rec_sdram_finished`  in  1: write accepted; one-cycle strobe from the arbiter.
- `rec_audio_valid`  in  1: sample available.
- `rec_audio_data`  in  32: sample.
- `rec_audio_ready`  out  1: core can accept a sample this cycle.

## Operation
- Registers:
  - `base` (23 bits)
  - `count` (23 bits): samples committed
  - `sample` (32 bits)
  - `stop_pending` (1 bit)
  - `state`
  - `rec_length`
  - `rec_done`
- IDLE: `rec_write`=0, `rec_audio_ready`=0.
  - `rec_start` → `base`←`rec_select`, `count`←0, `stop_pending`←0, go to WAIT.
  - `rec_stop` and `rec_pause` are ignored.
- WAIT: `rec_audio_ready` = !`rec_pause` && !`rec_stop`.
  - Priority 1: if `rec_stop`, go to WRITE_LENGTH. A sample presented that cycle is not accepted.
  - Priority 2: if `count`==`MAX_LEN`, go to WRITE_LENGTH.
  - Priority 3: if valid && ready, `sample`←`rec_audio_data`, go to WRITE.
  - Pause does not block stop.
- WRITE: `rec_write`=1, `rec_addr`=`base`+1+`count`, `rec_writedata`=`sample`.
  - `rec_stop` in this state sets `stop_pending`.
  - On finished: `count`←`count`+1.
    - If `stop_pending` (including a stop in the same cycle) or `count`+1==`MAX_LEN`, go to WRITE_LENGTH.
    - Otherwise go to WAIT.
  - An in-flight sample write is never aborted, so the stored length always matches the stored data.
- WRITE_LENGTH: `rec_write`=1, `rec_addr`=`base`, `rec_writedata`={9'b0, `count`}.
  - On finished: `rec_length`←`count`, `rec_done`←1 (registered), go to IDLE.
- Address arithmetic is modulo 2^23. Sample addresses wrap from 0x7FFFFF to 0x000000.
- `rec_addr` and `rec_writedata` are 0 whenever `rec_write`=0.
- PlayCore compatibility: PlayCore reads `len` at `base`, then samples `base`+1 … `base`+`len`. This block writes exactly that image.
- Zero-sample recording: stop straight from WAIT writes length 0.
- Reset mid-operation: return to IDLE and drop the request. No length word is written; SDRAM content is undefined for that region.

## Timing
- Reset values:
  - `state`=IDLE.
  - All outputs 0: `rec_done`, `rec_length`, `rec_write`, `rec_addr`, `rec_writedata`, `rec_audio_ready`.
- Start accepted at edge N: state is WAIT and ready=1 in cycle N+1.
- Sample handshake at edge k: `rec_write`=1 from cycle k+1.
- Finished at edge m: WAIT and ready from cycle m+1.
- Minimum period per sample is 2 cycles plus SDRAM latency. Zero-wait finished gives 1 sample per 2 cycles.
- Length-write finished at edge m: `rec_done`=1 for cycle m+1 only, `rec_length` valid from m+1, state IDLE at m+1.
- `rec_done` and a new `rec_start` may coincide. The start is accepted.
- `rec_write`, `rec_addr` and `rec_writedata` stay constant from request until the finished cycle.

## Test plan
- Basic: `base`=0x000100, samples 0xAAAA0001, 0xBBBB0002, 0xCCCC0003, then stop → writes at 0x101, 0x102, 0x103 in order, then 0x100←0x00000003. `rec_done` is a 1-cycle pulse and `rec_length`=3.
- Pause: hold pause 20 cycles with valid=1 → ready=0, no writes. Release → next sample written at `base`+1+`count`.
- Stop mid-write: stop pulsed during WRITE, finished delayed 5 cycles → sample completes, length written = samples including that one. Stop together with valid in WAIT → that sample is not accepted.
- Full: `MAX_LEN`=4, feed 6 samples with no stop → exactly 4 sample writes, then length 4, then done. ready stays 0 after the 4th.
- Wrap: `base`=0x7FFFFE, 2 samples → addresses 0x7FFFFF and 0x000000, then length 2 at 0x7FFFFE.
- Reset/empty:
  - Assert `i_rst` during WRITE → `rec_write` drops immediately and all outputs are 0. A following start with immediate stop writes length 0 at the new base and pulses done.
